// File: rtl/phase_seq_pkg.sv
// Shared types and constants for the phase strobe sequencer.
// Build option PHASE_SEQ_DENSE_EN selects the gapless 4-slot frame.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_e;

`ifdef PHASE_SEQ_DENSE_EN
  localparam int unsigned SLOT_W = 2;
`else
  localparam int unsigned SLOT_W = 3;
`endif
  localparam int unsigned SLOTS_PER_FRAME = 1 << SLOT_W;

  localparam logic [3:0] PH_C0 = 4'b0001;
  localparam logic [3:0] PH_C1 = 4'b0010;
  localparam logic [3:0] PH_C2 = 4'b0100;
  localparam logic [3:0] PH_C3 = 4'b1000;

  function automatic logic [3:0] slot_to_ph(input logic [SLOT_W-1:0] slot);
    logic [3:0] ph;
    ph = '0;
`ifdef PHASE_SEQ_DENSE_EN
    case (slot)
      2'd0:    ph = PH_C0;
      2'd1:    ph = PH_C1;
      2'd2:    ph = PH_C2;
      default: ph = PH_C3;
    endcase
`else
    // Odd slots are the non-overlap gaps between strobes.
    if (!slot[0]) begin
      case (slot[2:1])
        2'd0:    ph = PH_C0;
        2'd1:    ph = PH_C1;
        2'd2:    ph = PH_C2;
        default: ph = PH_C3;
      endcase
    end
`endif
    return ph;
  endfunction

endpackage

// File: rtl/phase_tick_div.sv
// Slot-length divider: counts 0..reload_i while enabled, ticks on the terminal count.
module phase_tick_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] reload_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == reload_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/phase_seq_ctrl.sv
// Burst sequencer for the 4-phase non-overlapping sync strobes (IDLE/ARM/RUN/DRAIN).
// Build option PHASE_SEQ_DENSE_EN: 4-slot frames with no gap slots.
module phase_seq_ctrl
  import phase_seq_pkg::*;
#(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned FRM_W = 16
) (
  input  logic             OSC,
  input  logic             RES_HARD,
  input  logic             CFG_WE,
  input  logic [DIV_W-1:0] CFG_DIV,
  input  logic [FRM_W-1:0] CFG_FRAMES,
  input  logic             START,
  input  logic             ABORT,
  output logic             BUSY,
  output logic             DONE,
  output logic             ABORTED,
  output logic             CFG_ERR,
  output logic [3:0]       PH,
  output logic [FRM_W-1:0] FRAME_CNT
);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS_PER_FRAME - 1);

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_sh_q, div_sh_d;
  logic [FRM_W-1:0]  frm_sh_q, frm_sh_d;
  logic [FRM_W-1:0]  fcnt_q, fcnt_d, fcnt_inc;
  logic [SLOT_W-1:0] slot_q, slot_d, slot_nxt;
  logic [3:0]        ph_q, ph_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              cfg_err_q, cfg_err_d;
  logic              abort_pend_q, abort_pend_d;
  logic              running, tick, frame_done, abort_req, limit_hit;

  assign running = (state_q == RUN) || (state_q == DRAIN);

  phase_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk_i   (OSC),
    .rst_i   (RES_HARD),
    .clr_i   (!running),
    .en_i    (running),
    .reload_i(div_sh_q),
    .tick_o  (tick)
  );

  assign slot_nxt   = tick ? slot_q + 1'b1 : slot_q;
  assign frame_done = tick && (slot_q == LAST_SLOT);
  assign fcnt_inc   = (fcnt_q == '1) ? fcnt_q : fcnt_q + 1'b1;
  assign limit_hit  = (frm_sh_q != '0) && (fcnt_inc == frm_sh_q);
  assign abort_req  = ABORT || abort_pend_q;

  always_comb begin
    state_d      = state_q;
    div_sh_d     = div_sh_q;
    frm_sh_d     = frm_sh_q;
    fcnt_d       = fcnt_q;
    slot_d       = slot_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    ph_d         = '0;
    done_d       = 1'b0;
    cfg_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (CFG_WE) begin
          div_sh_d = CFG_DIV;
          frm_sh_d = CFG_FRAMES;
        end
        if (START) begin
          state_d      = ARM;
          fcnt_d       = '0;
          slot_d       = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
        end
      end
      ARM: begin
        cfg_err_d = CFG_WE;
        if (ABORT) abort_pend_d = 1'b1;
        state_d = RUN;
        slot_d  = '0;
        ph_d    = slot_to_ph('0);
      end
      RUN, DRAIN: begin
        cfg_err_d    = CFG_WE;
        abort_pend_d = 1'b0;
        slot_d       = slot_nxt;
        if (frame_done) fcnt_d = fcnt_inc;
        // An abort landing on the frame's last tick is honoured at that same boundary.
        if (frame_done && (state_q == DRAIN || limit_hit || abort_req)) begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (state_q == RUN && abort_req) aborted_d = 1'b1;
        end else begin
          ph_d = slot_to_ph(slot_nxt);
          if (state_q == RUN && abort_req) begin
            state_d   = DRAIN;
            aborted_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge OSC) begin
    if (RES_HARD) begin
      state_q      <= IDLE;
      div_sh_q     <= '0;
      frm_sh_q     <= FRM_W'(1);
      fcnt_q       <= '0;
      slot_q       <= '0;
      ph_q         <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      cfg_err_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_sh_q     <= div_sh_d;
      frm_sh_q     <= frm_sh_d;
      fcnt_q       <= fcnt_d;
      slot_q       <= slot_d;
      ph_q         <= ph_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      cfg_err_q    <= cfg_err_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign BUSY      = (state_q != IDLE);
  assign DONE      = done_q;
  assign ABORTED   = aborted_q;
  assign CFG_ERR   = cfg_err_q;
  assign PH        = ph_q;
  assign FRAME_CNT = fcnt_q;

endmodule

// File: doc/phase_seq_ctrl.md
Name: phase_seq_ctrl

Overview:
- Sequencer for the 4-phase non-overlapping sync strobes.
- Runs a programmable divider and sequences a finite or continuous burst of 8-slot frames on command, with strobes on the even slots.
- Start/abort/done handshake and a config-load port with busy protection.
- Sits between the host control register block and the analog-frontend phase inputs.

Parameters:
- DIV_W, 8, divider reload width (slot length = CFG_DIV+1 OSC cycles)
- FRM_W, 16, frame-count width

Ports:
- OSC  in  1  system clock; all logic on posedge
- RES_HARD  in  1  synchronous, active-high reset
- CFG_WE  in  1  load CFG_DIV/CFG_FRAMES into shadow registers
- CFG_DIV  in  DIV_W  slot length minus one
- CFG_FRAMES  in  FRM_W  frames per burst; 0 = continuous
- START  in  1  start-burst request (level sampled each cycle)
- ABORT  in  1  stop request; honoured at the next frame boundary
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle pulse when a burst ends
- ABORTED  out  1  sticky: last burst ended by ABORT; cleared on next START
- CFG_ERR  out  1  one-cycle pulse: CFG_WE rejected because BUSY
- PH  out  4  one-hot phase strobes {C3,C2,C1,C0}
- FRAME_CNT  out  FRM_W  frames completed in current or last burst

Behaviour:
- Reset (synchronous, RES_HARD=1 at posedge):
  - State IDLE.
  - PH=0, BUSY=0, DONE=0, ABORTED=0, CFG_ERR=0, FRAME_CNT=0.
  - Shadow DIV=0, shadow FRAMES=1.
  - Reset mid-burst aborts immediately: no DONE pulse, PH=0 next cycle.
- Config:
  - In IDLE, CFG_WE=1 loads both shadows at the posedge.
  - In any other state, CFG_WE is ignored and CFG_ERR pulses for one cycle.
- States: IDLE, ARM, RUN, DRAIN.
- IDLE -> ARM:
  - Taken when START=1.
  - If CFG_WE=1 in the same cycle, the new config is used.
  - ARM (1 cycle): BUSY=1; clear divider, slot and FRAME_CNT; clear ABORTED.
- ARM -> RUN:
  - Always.
  - Slot counter (3 bits) starts at 0.
  - Divider counts 0..DIV; tick when divider==DIV, then divider reloads to 0.
  - Each slot holds for DIV+1 cycles; slot advances on tick and wraps 7->0.
- PH output:
  - Registered.
  - PH=one-hot(slot>>1) when slot is even; PH=0 on odd slots.
  - PH is always 0 outside RUN/DRAIN.
- Frame completion:
  - Frame completes on the tick with slot==7; FRAME_CNT increments, saturating at all-ones.
  - In RUN at frame completion: if FRAMES!=0 and new FRAME_CNT==FRAMES -> IDLE.
- Abort:
  - ABORT=1 in RUN -> DRAIN; ABORTED set.
  - DRAIN behaves like RUN but exits to IDLE at the next frame completion.
  - ABORT in ARM is held as a pending flag and takes effect in the first RUN cycle.
  - ABORT in IDLE is ignored.
- On entry to IDLE from RUN/DRAIN:
  - DONE=1 for exactly that cycle; BUSY=0 that same cycle; PH=0.
- START while BUSY is ignored. START held high in the DONE cycle re-arms the next cycle.
- Latency:
  - START sampled at posedge t -> BUSY high at t+1 -> PH=0001 from t+2.
  - Burst length in RUN = FRAMES*8*(DIV+1) cycles.
- DIV=0 gives one-cycle slots, i.e. strobes one cycle wide with one-cycle gaps.

Optional Feature:
- Macro PHASE_SEQ_DENSE_EN.
- Defined: frame = 4 slots (slot counter 2 bits, wraps 3->0), PH=one-hot(slot) with no gap slots. Frame completes on the tick with slot==3. Burst length = FRAMES*4*(DIV+1) cycles.
- Undefined: 8-slot gapped frame as above.

Decomposition:
- Package phase_seq_pkg:
  - state enum {IDLE, ARM, RUN, DRAIN}
  - SLOT_W and SLOTS_PER_FRAME constants (selected by the macro)
  - phase one-hot constants PH_C0..PH_C3
  - function slot_to_ph
- Sub-module phase_tick_div: clear, enable, reload value in; one-cycle tick out.
- FSM, slot counter and frame counter stay in phase_seq_ctrl.

Test Plan:
- Reset, CFG_WE DIV=2 FRAMES=1, START -> BUSY at t+1. PH=0001 for 3 cycles, 0 for 3, 0010, 0, 0100, 0, 1000, 0. DONE one pulse at t+26, FRAME_CNT=1.
- DIV=0 FRAMES=3 -> 24 RUN cycles of alternating one-hot/zero PH. DONE once, FRAME_CNT=3, no PH after DONE.
- FRAMES=0 DIV=1, ABORT asserted mid-slot 3 of frame 5 -> PH continues to end of frame 5 (slot 7). DONE, ABORTED=1, FRAME_CNT=5.
- CFG_WE with DIV=9 during RUN -> CFG_ERR pulse; slot timing unchanged. After DONE, CFG_WE accepted and the next burst uses 10-cycle slots.
- RES_HARD asserted mid-RUN -> next cycle PH=0, BUSY=0, DONE=0, FRAME_CNT=0. Shadows return to DIV=0/FRAMES=1.
- With PHASE_SEQ_DENSE_EN, DIV=0 FRAMES=2 -> PH sequence 0001, 0010, 0100, 1000 repeated twice with no gaps. DONE after 8 RUN cycles.
